// File: rtl/mem_dump_engine.sv
// rtl/mem_dump_engine.sv - walks main memory and streams (address, data) pairs downstream
//
// Optional feature macro: MEM_DUMP_SKIP_INVALID_EN
//   defined   : locations returned with mem_rd_valid=0 are skipped and not counted
//   undefined : every address in the range is emitted and counted
//
// Ports:
//   clock, resetN            system clock, asynchronous active-low reset
//   start                    one-cycle pulse, accepted only in IDLE
//   start_addr, end_addr     inclusive dump range, sampled on start (wraps if start > end)
//   busy, done               dump in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr      one-cycle read request and held read address
//   mem_rd_data, mem_rd_valid, mem_rd_ack   read response
//   out_valid, out_ready, out_addr, out_data   pair stream with valid/ready handshake
//   word_count               pairs accepted downstream in the current or last dump

module mem_dump_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    input  logic              mem_rd_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   word_count
);

    // The engine never pipelines reads, so the latency only has to be legal;
    // the FSM simply waits in WAIT for the acknowledge.
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("mem_dump_engine: RD_LAT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
        NEXT,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] lim_addr;
    logic              emit;

`ifdef MEM_DUMP_SKIP_INVALID_EN
    assign emit = mem_rd_valid;
`else
    logic unused_valid;
    assign emit         = 1'b1;
    assign unused_valid = mem_rd_valid;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            cur_addr   <= '0;
            lim_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            word_count <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr   <= start_addr;
                        lim_addr   <= end_addr;
                        word_count <= '0;
                        busy       <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= cur_addr;
                    state     <= WAIT;
                end
                WAIT: begin
                    // mem_addr is left untouched here, keeping it stable until the ack.
                    if (mem_rd_ack) begin
                        out_data <= mem_rd_data;
                        out_addr <= cur_addr;
                        if (emit) begin
                            out_valid <= 1'b1;
                            state     <= SEND;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b0;
                        word_count <= word_count + 1'b1;
                        state      <= NEXT;
                    end
                end
                NEXT: begin
                    // Equality test (not magnitude) lets a range wrap through the top of memory.
                    if (cur_addr == lim_addr) begin
                        state <= DONE;
                    end else begin
                        cur_addr <= cur_addr + 1'b1;
                        state    <= REQ;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_engine.sv
// tb/tb_mem_dump_engine.sv - directed self-checking bench for mem_dump_engine
module tb_mem_dump_engine;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 12;
    localparam int RD_LAT = 2;

    logic              clock = 1'b0;
    logic              resetN = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              mem_rd_valid = 1'b0;
    logic              mem_rd_ack = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   word_count;

    mem_dump_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .resetN(resetN), .start(start),
        .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_rd_ack(mem_rd_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Memory model: ack driven on the negedge so the DUT samples it RD_LAT edges after mem_rd_en.
    logic [DATA_W-1:0] mem [4096];
    logic              mem_v [4096];
    int                lat_cnt = 0;

    always @(negedge clock) begin
        mem_rd_ack = 1'b0;
        if (!resetN) begin
            lat_cnt = 0;
        end else begin
            if (mem_rd_en) lat_cnt = RD_LAT;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_rd_ack   = 1'b1;
                    mem_rd_data  = mem[mem_addr];
                    mem_rd_valid = mem_v[mem_addr];
                end
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = 5 stall cycles per pair, 2 = never ready.
    int rmode = 0;
    int stall = 0;
    always @(posedge clock) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin
                if (out_valid) begin
                    if (stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end else begin
                    out_ready = 1'b0;
                    stall = 0;
                end
            end
            default: out_ready = 1'b0;
        endcase
    end

    // Stream collector and hold-stability monitor.
    logic [ADDR_W-1:0] got_addr [$];
    logic [DATA_W-1:0] got_data [$];
    int                done_cnt = 0;
    int                stall_cnt = 0;
    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_a = '0;
    logic [DATA_W-1:0] prev_d = '0;

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            got_addr.push_back(out_addr);
            got_data.push_back(out_data);
        end
        if (prev_stall && out_valid) begin
            check_eq("hold_addr", {20'b0, out_addr}, {20'b0, prev_a});
            check_eq("hold_data", {20'b0, out_data}, {20'b0, prev_d});
        end
        prev_stall = out_valid && !out_ready;
        prev_a = out_addr;
        prev_d = out_data;
        if (prev_stall) stall_cnt++;
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea);
        @(posedge clock); #1;
        start_addr = sa;
        end_addr = ea;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_done_seen"}, {31'b0, done_cnt != d0}, 32'd1);
    endtask

    task automatic check_pairs(input string tag, input logic [ADDR_W-1:0] ea [$],
                               input logic [DATA_W-1:0] ed [$]);
        check_eq({tag, "_count"}, got_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), {20'b0, got_addr[i]}, {20'b0, ea[i]});
            check_eq($sformatf("%s_data%0d", tag, i), {20'b0, got_data[i]}, {20'b0, ed[i]});
        end
    endtask

    task automatic clear_q();
        got_addr.delete();
        got_data.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        int errs;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = i[11:0] ^ 12'o5252;
            mem_v[i] = 1'b1;
        end
        mem[12'o0200] = 12'o7200;
        mem[12'o0201] = 12'o1205;
        mem[12'o0202] = 12'o7402;
        mem[12'o0300] = 12'o3003;
        mem[12'o7776] = 12'o1234;
        mem[12'o7777] = 12'o4321;
        mem[12'o0000] = 12'o0055;
        mem[12'o0001] = 12'o6000;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_rd_en", {31'b0, mem_rd_en}, 0);
        check_eq("rst_mem_addr", {20'b0, mem_addr}, 0);
        check_eq("rst_out_valid", {31'b0, out_valid}, 0);
        check_eq("rst_out_addr", {20'b0, out_addr}, 0);
        check_eq("rst_out_data", {20'b0, out_data}, 0);
        check_eq("rst_word_count", {19'b0, word_count}, 0);
        @(posedge clock); #1;
        resetN = 1'b1;

        // 1. Basic dump
        rmode = 0;
        clear_q();
        d0 = done_cnt;
        pulse_start(12'o0200, 12'o0202);
        wait_done(d0, 200, "t1");
        repeat (10) @(negedge clock);
        check_pairs("t1", '{12'o0200, 12'o0201, 12'o0202}, '{12'o7200, 12'o1205, 12'o7402});
        check_eq("t1_wc", {19'b0, word_count}, 3);
        check_eq("t1_done_pulses", done_cnt - d0, 1);
        check_eq("t1_busy_idle", {31'b0, busy}, 0);

        // 2. Backpressure: 5 stalled cycles per pair
        rmode = 1;
        clear_q();
        stall_cnt = 0;
        d0 = done_cnt;
        pulse_start(12'o0200, 12'o0202);
        wait_done(d0, 300, "t2");
        repeat (5) @(negedge clock);
        check_pairs("t2", '{12'o0200, 12'o0201, 12'o0202}, '{12'o7200, 12'o1205, 12'o7402});
        check_eq("t2_wc", {19'b0, word_count}, 3);
        check_eq("t2_stall_cycles", stall_cnt, 15);
        rmode = 0;

        // 3. Wrap through 7777
        clear_q();
        d0 = done_cnt;
        pulse_start(12'o7776, 12'o0001);
        wait_done(d0, 300, "t3");
        repeat (5) @(negedge clock);
        check_pairs("t3", '{12'o7776, 12'o7777, 12'o0000, 12'o0001},
                    '{12'o1234, 12'o4321, 12'o0055, 12'o6000});
        check_eq("t3_wc", {19'b0, word_count}, 4);

        // 4. Full range with only 0200, 0201, 0300 valid
        for (int i = 0; i < 4096; i++) mem_v[i] = 1'b0;
        mem_v[12'o0200] = 1'b1;
        mem_v[12'o0201] = 1'b1;
        mem_v[12'o0300] = 1'b1;
        clear_q();
        d0 = done_cnt;
        pulse_start(12'o0000, 12'o7777);
        wait_done(d0, 40000, "t4");
        repeat (5) @(negedge clock);
`ifdef MEM_DUMP_SKIP_INVALID_EN
        check_pairs("t4", '{12'o0200, 12'o0201, 12'o0300}, '{12'o7200, 12'o1205, 12'o3003});
        check_eq("t4_wc", {19'b0, word_count}, 3);
`else
        check_eq("t4_count", got_addr.size(), 4096);
        errs = 0;
        for (int i = 0; i < 4096 && i < got_addr.size(); i++) begin
            if (got_addr[i] !== i[11:0] || got_data[i] !== mem[i]) errs++;
        end
        check_eq("t4_pair_errors", errs, 0);
        check_eq("t4_wc", {19'b0, word_count}, 4096);
`endif
        for (int i = 0; i < 4096; i++) mem_v[i] = 1'b1;

        // 5. start while busy is ignored
        clear_q();
        d0 = done_cnt;
        pulse_start(12'o0200, 12'o0202);
        n = 0;
        while (got_addr.size() < 1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("t5_first_pair_seen", {31'b0, got_addr.size() >= 1}, 1);
        pulse_start(12'o0300, 12'o0301);
        wait_done(d0, 300, "t5");
        repeat (30) @(negedge clock);
        check_pairs("t5", '{12'o0200, 12'o0201, 12'o0202}, '{12'o7200, 12'o1205, 12'o7402});
        check_eq("t5_done_pulses", done_cnt - d0, 1);
        check_eq("t5_busy_idle", {31'b0, busy}, 0);
        check_eq("t5_wc", {19'b0, word_count}, 3);

        // 6. Asynchronous reset during SEND, then a fresh dump
        rmode = 2;
        clear_q();
        d0 = done_cnt;
        pulse_start(12'o0200, 12'o0202);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_eq("t6_in_send", {31'b0, out_valid}, 1);
        #1;
        resetN = 1'b0;
        #1;
        check_eq("t6_out_valid", {31'b0, out_valid}, 0);
        check_eq("t6_busy", {31'b0, busy}, 0);
        check_eq("t6_rd_en", {31'b0, mem_rd_en}, 0);
        check_eq("t6_wc", {19'b0, word_count}, 0);
        repeat (3) @(negedge clock);
        check_eq("t6_no_done", done_cnt - d0, 0);
        @(posedge clock); #1;
        resetN = 1'b1;
        rmode = 0;
        clear_q();
        d0 = done_cnt;
        pulse_start(12'o0201, 12'o0202);
        wait_done(d0, 200, "t6b");
        repeat (5) @(negedge clock);
        check_pairs("t6b", '{12'o0201, 12'o0202}, '{12'o1205, 12'o7402});
        check_eq("t6b_wc", {19'b0, word_count}, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_dump_engine.md
Name: mem_dump_engine

Overview:
- Hardware reader that walks the 4096-word PDP-8 main memory and streams (address, data) pairs out over a valid/ready handshake.
- It is the counterpart of the front-panel deposit path that loads memory, and is used for post-run memory dumps and image comparison.
- Sits beside memory_controller.
- Owns the memory read port only while a dump is active.

Parameters:
- ADDR_W, 12, memory address width in bits; memory depth is 2**ADDR_W.
- DATA_W, 12, memory word width in bits.
- RD_LAT, 2, memory read latency in clocks from mem_rd_en to mem_rd_ack; must be >= 1.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a dump; ignored unless the FSM is in IDLE.
- start_addr  in  ADDR_W  first address to dump; sampled on start.
- end_addr  in  ADDR_W  last address to dump, inclusive; sampled on start.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when the final pair has been accepted downstream.
- mem_rd_en  out  1  one-cycle read request.
- mem_addr  out  ADDR_W  read address; held stable from mem_rd_en through mem_rd_ack.
- mem_rd_data  in  DATA_W  read data; valid while mem_rd_ack is high.
- mem_rd_valid  in  1  location-valid bit, returned alongside mem_rd_data.
- mem_rd_ack  in  1  read-complete strobe, RD_LAT cycles after mem_rd_en.
- out_valid  out  1  a stream pair is available.
- out_ready  in  1  downstream accepts the pair.
- out_addr  out  ADDR_W  address of the current pair.
- out_data  out  DATA_W  memory contents of the current pair.
- word_count  out  ADDR_W+1  number of pairs accepted downstream in the current or last dump.

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_addr=0, out_data=0, word_count=0. FSM=IDLE.
- FSM states: IDLE, REQ, WAIT, SEND, NEXT, DONE.
- IDLE:
  - On start, latch start_addr into the current address and end_addr into the limit.
  - Clear word_count, then go to REQ.
  - If start_addr > end_addr, the range wraps through 07777 to 0000.
- REQ: assert mem_rd_en for exactly one cycle with mem_addr = current address; go to WAIT.
- WAIT:
  - Hold mem_addr stable.
  - On mem_rd_ack, capture mem_rd_data into out_data and the current address into out_addr.
  - If the pair is to be emitted (see Optional Feature), set out_valid and go to SEND; otherwise go to NEXT.
- SEND:
  - Hold out_valid, out_addr and out_data stable until out_valid && out_ready.
  - On that handshake cycle: clear out_valid, increment word_count, go to NEXT.
  - out_ready may be high before out_valid rises; that case completes the transfer in the first SEND cycle.
- NEXT:
  - If the current address equals the limit, go to DONE.
  - Otherwise increment the current address modulo 2**ADDR_W and go to REQ.
- DONE: pulse done for one cycle, deassert busy, return to IDLE.
- Throughput: at most one pair every RD_LAT+3 cycles. No read pipelining; only one outstanding read at a time.
- start while busy is ignored; it does not restart the dump or change the latched range.
- Full range: start_addr=0000, end_addr=7777 dumps 4096 locations. word_count reaches 4096, which needs the extra bit.
- A mem_rd_ack outside WAIT is ignored.
- Reset mid-dump: all outputs return to reset values immediately (asynchronous). No done pulse. A partially accepted stream is abandoned.

Optional Feature:
- Macro: MEM_DUMP_SKIP_INVALID_EN.
- Defined: in WAIT, a location with mem_rd_valid=0 is not emitted and goes straight to NEXT. word_count counts only valid locations. A range with no valid locations still produces done, with word_count=0.
- Not defined: every address in the range is emitted regardless of mem_rd_valid, and word_count = range length.

Test Plan:
1. Basic dump:
   - Stimulus: preload 0200=7200, 0201=1205, 0202=7402; start with 0200..0202; out_ready held 1.
   - Required response: pairs (0200,7200), (0201,1205), (0202,7402) in order; one done pulse; word_count=3.
2. Backpressure:
   - Stimulus: same range as test 1; out_ready low for 5 cycles while out_valid is high.
   - Required response: out_addr and out_data stable throughout; no duplicated or dropped pair; word_count=3.
3. Wrap:
   - Stimulus: start 7776..0001.
   - Required response: addresses 7776, 7777, 0000, 0001 emitted in that order; word_count=4.
4. Skip invalid (macro defined):
   - Stimulus: dump 0000..7777 with only 0200, 0201 and 0300 valid.
   - Required response: exactly those 3 pairs emitted; word_count=3.
   - Same test with the macro undefined: 4096 pairs emitted; word_count=4096.
5. start while busy:
   - Stimulus: pulse start with a new range during the 2nd pair of a dump.
   - Required response: the original range completes unchanged; a single done pulse.
6. Reset mid-operation:
   - Stimulus: assert resetN low during SEND.
   - Required response: out_valid=0, busy=0 and mem_rd_en=0 in the same cycle.
   - Then: a fresh start dumps correctly.
